// File: rtl/alu_operand_stage_if.sv
// Handshake and operand bus between decode, the operand stage and the ALU.
// master: the decode/ALU side that drives ops in and consumes results.
// slave:  the operand stage itself.
interface alu_operand_stage_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int REG_AW = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_control;
    logic [REG_AW-1:0] in_rs;
    logic [REG_AW-1:0] in_rt;
    logic [DATA_W-1:0] in_rs_val;
    logic [DATA_W-1:0] in_rt_val;
    logic              in_use_imm;
    logic [DATA_W-1:0] in_imm;
    logic [REG_AW-1:0] in_rd;
    logic              ex_wen;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_data;
    logic              wb_wen;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] control;
    logic [DATA_W-1:0] oper1;
    logic [DATA_W-1:0] oper2;
    logic [REG_AW-1:0] out_rd;

    modport master (
        output flush, in_valid, in_control, in_rs, in_rt, in_rs_val, in_rt_val,
               in_use_imm, in_imm, in_rd, ex_wen, ex_rd, ex_data, wb_wen, wb_rd,
               wb_data, out_ready,
        input  in_ready, out_valid, control, oper1, oper2, out_rd
    );

    modport slave (
        input  flush, in_valid, in_control, in_rs, in_rt, in_rs_val, in_rt_val,
               in_use_imm, in_imm, in_rd, ex_wen, ex_rd, ex_data, wb_wen, wb_rd,
               wb_data, out_ready,
        output in_ready, out_valid, control, oper1, oper2, out_rd
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Decode-to-execute operand stage: resolves oper1/oper2 at push time and holds
// up to two ops in a skid buffer in front of the ALU.
// Slot 0 is always the head, so the ALU-facing outputs come straight from its
// registers; slot 1 shifts into slot 0 when the head pops with a second op behind it.
// Optional feature macro: ALU_OPSTAGE_FWD_EN enables EX/WB forwarding at push and
// the WB snoop on resident entries. Without it the ex_* and wb_* signals are ignored.
module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int REG_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    alu_operand_stage_if.slave bus
);

    // Payload presented to the ALU.
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [REG_AW-1:0] rd;
    } pay_t;

    logic [1:0] r_count;
    pay_t       r_pay     [2];
    pay_t       w_pay_snp [2];
    pay_t       w_pay_nxt [2];
    pay_t       w_new_pay;
    logic [1:0] w_count_nxt;
    logic       w_in_ready;
    logic       w_push;
    logic       w_pop;
    logic       w_wr_slot0;

`ifdef ALU_OPSTAGE_FWD_EN
    // Source-register tags, kept only so resident operands can snoop writeback.
    typedef struct packed {
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              use_imm;
    } tag_t;

    tag_t r_tag     [2];
    tag_t w_tag_nxt [2];
    tag_t w_new_tag;

    assign w_new_tag = {bus.in_rs, bus.in_rt, bus.in_use_imm};
`endif

    assign w_in_ready = !rst && (r_count < 2'd2);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = (r_count != 2'd0) && bus.out_ready;
    // The incoming op lands in slot 0 if the buffer is (or is becoming) empty.
    assign w_wr_slot0 = (r_count == 2'd0) || ((r_count == 2'd1) && w_pop);

    // Resolve operands of the incoming op: r0, then EX, then WB, then regfile; imm overrides oper2.
    always_comb begin
        w_new_pay.ctrl = bus.in_control;
        w_new_pay.rd   = bus.in_rd;
        w_new_pay.op1  = bus.in_rs_val;
        w_new_pay.op2  = bus.in_rt_val;
`ifdef ALU_OPSTAGE_FWD_EN
        if (bus.wb_wen && (bus.wb_rd == bus.in_rs)) w_new_pay.op1 = bus.wb_data;
        if (bus.ex_wen && (bus.ex_rd == bus.in_rs)) w_new_pay.op1 = bus.ex_data;
        if (bus.wb_wen && (bus.wb_rd == bus.in_rt)) w_new_pay.op2 = bus.wb_data;
        if (bus.ex_wen && (bus.ex_rd == bus.in_rt)) w_new_pay.op2 = bus.ex_data;
`endif
        if (bus.in_rs == '0) w_new_pay.op1 = '0;
        if (bus.in_rt == '0) w_new_pay.op2 = '0;
        if (bus.in_use_imm)  w_new_pay.op2 = bus.in_imm;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
`ifdef ALU_OPSTAGE_FWD_EN
            pay_t w_snp;
            logic w_hit;

            assign w_hit = (r_count > 2'(gi)) && bus.wb_wen && (bus.wb_rd != '0);

            // Refresh resident operands that the writeback port is writing this cycle.
            always_comb begin
                w_snp = r_pay[gi];
                if (w_hit && (r_tag[gi].rs == bus.wb_rd))
                    w_snp.op1 = bus.wb_data;
                if (w_hit && !r_tag[gi].use_imm && (r_tag[gi].rt == bus.wb_rd))
                    w_snp.op2 = bus.wb_data;
            end

            assign w_pay_snp[gi] = w_snp;
`else
            assign w_pay_snp[gi] = r_pay[gi];
`endif
        end
    endgenerate

    // Next buffer contents: shift on pop from a full buffer, then append the push.
    always_comb begin
        w_count_nxt  = r_count;
        w_pay_nxt[0] = w_pay_snp[0];
        w_pay_nxt[1] = w_pay_snp[1];
`ifdef ALU_OPSTAGE_FWD_EN
        w_tag_nxt[0] = r_tag[0];
        w_tag_nxt[1] = r_tag[1];
`endif
        if (bus.flush) begin
            w_count_nxt = 2'd0;
        end else begin
            if (w_pop && (r_count == 2'd2)) begin
                w_pay_nxt[0] = w_pay_snp[1];
`ifdef ALU_OPSTAGE_FWD_EN
                w_tag_nxt[0] = r_tag[1];
`endif
            end
            if (w_push) begin
                if (w_wr_slot0) begin
                    w_pay_nxt[0] = w_new_pay;
`ifdef ALU_OPSTAGE_FWD_EN
                    w_tag_nxt[0] = w_new_tag;
`endif
                end else begin
                    w_pay_nxt[1] = w_new_pay;
`ifdef ALU_OPSTAGE_FWD_EN
                    w_tag_nxt[1] = w_new_tag;
`endif
                end
            end
            w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Buffer state registers; reset clears occupancy and the visible head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= 2'd0;
            r_pay[0] <= '0;
            r_pay[1] <= '0;
        end else begin
            r_count  <= w_count_nxt;
            r_pay[0] <= w_pay_nxt[0];
            r_pay[1] <= w_pay_nxt[1];
        end
    end

`ifdef ALU_OPSTAGE_FWD_EN
    // Source tags follow their payload through the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag[0] <= '0;
            r_tag[1] <= '0;
        end else begin
            r_tag[0] <= w_tag_nxt[0];
            r_tag[1] <= w_tag_nxt[1];
        end
    end
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.control   = r_pay[0].ctrl;
    assign bus.oper1     = r_pay[0].op1;
    assign bus.oper2     = r_pay[0].op2;
    assign bus.out_rd    = r_pay[0].rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a queue-based reference model.
// Expectations follow ALU_OPSTAGE_FWD_EN when it is defined for the build.
module tb_alu_operand_stage;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;
    localparam int REG_AW = 5;
`ifdef ALU_OPSTAGE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_operand_stage_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .REG_AW(REG_AW)) bus ();

    alu_operand_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .REG_AW(REG_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        use_imm;
    } ent_t;

    typedef struct {
        logic [3:0]  ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic        use_imm;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        ex_wen;
        logic [4:0]  ex_rd;
        logic [31:0] ex_data;
        logic        wb_wen;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
    } vec_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endfunction

    // Operand value an op should carry, straight from the selection rules.
    function automatic logic [31:0] resolve(logic [4:0] r, logic [31:0] v);
        if (r == 5'd0) return 32'd0;
        if (FWD && bus.ex_wen && (bus.ex_rd == r)) return bus.ex_data;
        if (FWD && bus.wb_wen && (bus.wb_rd == r)) return bus.wb_data;
        return v;
    endfunction

    function automatic ent_t new_entry();
        ent_t e;
        e.ctrl    = bus.in_control;
        e.rd      = bus.in_rd;
        e.rs      = bus.in_rs;
        e.rt      = bus.in_rt;
        e.use_imm = bus.in_use_imm;
        e.op1     = resolve(bus.in_rs, bus.in_rs_val);
        e.op2     = bus.in_use_imm ? bus.in_imm : resolve(bus.in_rt, bus.in_rt_val);
        return e;
    endfunction

    task automatic set_idle();
        bus.flush = 0; bus.in_valid = 0; bus.in_control = 0; bus.in_rs = 0; bus.in_rt = 0;
        bus.in_rs_val = 0; bus.in_rt_val = 0; bus.in_use_imm = 0; bus.in_imm = 0; bus.in_rd = 0;
        bus.ex_wen = 0; bus.ex_rd = 0; bus.ex_data = 0; bus.wb_wen = 0; bus.wb_rd = 0;
        bus.wb_data = 0; bus.out_ready = 0;
    endtask

    task automatic drive_op(logic [3:0] c, logic [4:0] rs, logic [4:0] rt, logic [31:0] rsv,
                            logic [31:0] rtv, logic ui, logic [31:0] imm, logic [4:0] rd);
        bus.in_valid = 1; bus.in_control = c; bus.in_rs = rs; bus.in_rt = rt;
        bus.in_rs_val = rsv; bus.in_rt_val = rtv; bus.in_use_imm = ui; bus.in_imm = imm;
        bus.in_rd = rd;
    endtask

    // One clock: check in_ready, advance the model across the edge, check the head.
    task automatic cycle();
        ent_t        e;
        bit          push, pop, rst_s, flush_s, wbw;
        logic [4:0]  wbr;
        logic [31:0] wbd;
        int          sz;
        #1;
        sz      = q.size();
        rst_s   = rst;
        flush_s = bus.flush;
        chk("in_ready", 32'(bus.in_ready), 32'(!rst_s && (sz < 2)));
        push = bus.in_valid && !rst_s && (sz < 2);
        pop  = (sz > 0) && bus.out_ready;
        e    = new_entry();
        wbw  = bus.wb_wen; wbr = bus.wb_rd; wbd = bus.wb_data;
        @(posedge clk);
        #1;
        if (rst_s || flush_s) begin
            q.delete();
        end else begin
            if (FWD && wbw && (wbr != 5'd0)) begin
                foreach (q[i]) begin
                    if (q[i].rs == wbr) q[i].op1 = wbd;
                    if (!q[i].use_imm && (q[i].rt == wbr)) q[i].op2 = wbd;
                end
            end
            if (pop) begin
                $display("op ctrl=%0d rd=%0d oper1=%h oper2=%h", q[0].ctrl, q[0].rd, q[0].op1, q[0].op2);
                void'(q.pop_front());
            end
            if (push) q.push_back(e);
        end
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("control", 32'(bus.control), 32'(q[0].ctrl));
            chk("oper1", bus.oper1, q[0].op1);
            chk("oper2", bus.oper2, q[0].op2);
            chk("out_rd", 32'(bus.out_rd), 32'(q[0].rd));
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{4'd0, 5'd1, 5'd2, 32'd5, 32'd7, 1'b0, 32'd0, 5'd9,
                    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd7};
        vecs[1] = '{4'd1, 5'd3, 5'd2, 32'd1, 32'd7, 1'b0, 32'd0, 5'd3,
                    1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20, (FWD ? 32'h10 : 32'd1), 32'd7};
        vecs[2] = '{4'd2, 5'd0, 5'd5, 32'h77, 32'h33, 1'b0, 32'd0, 5'd4,
                    1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 32'd0, 32'h33};
        vecs[3] = '{4'd3, 5'd6, 5'd6, 32'd3, 32'd4, 1'b0, 32'd0, 5'd6,
                    1'b1, 5'd7, 32'h44, 1'b1, 5'd6, 32'h20, (FWD ? 32'h20 : 32'd3), (FWD ? 32'h20 : 32'd4)};
        vecs[4] = '{4'd4, 5'd2, 5'd4, 32'h12, 32'h13, 1'b1, 32'd9, 5'd1,
                    1'b1, 5'd4, 32'h66, 1'b1, 5'd4, 32'h67, 32'h12, 32'd9};
        vecs[5] = '{4'd10, 5'd5, 5'd0, 32'hCAFE, 32'hDEAD, 1'b0, 32'd0, 5'd31,
                    1'b1, 5'd6, 32'd1, 1'b1, 5'd7, 32'd2, 32'hCAFE, 32'd0};

        rst = 1;
        set_idle();
        cycle();
        cycle();
        rst = 0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_control", 32'(bus.control), 32'd0);
        chk("rst_oper1", bus.oper1, 32'd0);
        chk("rst_oper2", bus.oper2, 32'd0);
        chk("rst_out_rd", 32'(bus.out_rd), 32'd0);

        // Directed vector table: push into an empty buffer, check head, then drain.
        for (int i = 0; i < 6; i++) begin
            set_idle();
            drive_op(vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].rs_val, vecs[i].rt_val,
                     vecs[i].use_imm, vecs[i].imm, vecs[i].rd);
            bus.ex_wen = vecs[i].ex_wen; bus.ex_rd = vecs[i].ex_rd; bus.ex_data = vecs[i].ex_data;
            bus.wb_wen = vecs[i].wb_wen; bus.wb_rd = vecs[i].wb_rd; bus.wb_data = vecs[i].wb_data;
            cycle();
            chk("vec_valid", 32'(bus.out_valid), 32'd1);
            chk("vec_control", 32'(bus.control), 32'(vecs[i].ctrl));
            chk("vec_oper1", bus.oper1, vecs[i].e_op1);
            chk("vec_oper2", bus.oper2, vecs[i].e_op2);
            set_idle();
            bus.out_ready = 1;
            cycle();
        end

        // Stall: third push is refused, then ops drain in order.
        set_idle();
        for (int k = 0; k < 3; k++) begin
            drive_op(4'(k), 5'(k + 1), 5'd2, 32'h100 + 32'(k), 32'd0, 1'b0, 32'd0, 5'(k + 8));
            if (k == 2) begin
                #1;
                chk("full_in_ready", 32'(bus.in_ready), 32'd0);
            end
            cycle();
        end
        set_idle();
        bus.out_ready = 1;
        for (int k = 0; k < 2; k++) begin
            chk("drain_oper1", bus.oper1, 32'h100 + 32'(k));
            cycle();
        end
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        // WB snoop on a stalled head, register and immediate flavours.
        for (int k = 0; k < 2; k++) begin
            set_idle();
            drive_op(4'd0, 5'd1, 5'd4, 32'd1, 32'h11, k[0], 32'd9, 5'd2);
            cycle();
            set_idle();
            bus.wb_wen = 1; bus.wb_rd = 5'd4; bus.wb_data = 32'hABCD;
            cycle();
            if (k == 0) chk("snoop_oper2", bus.oper2, FWD ? 32'hABCD : 32'h11);
            else        chk("snoop_imm_oper2", bus.oper2, 32'd9);
            set_idle();
            bus.out_ready = 1;
            cycle();
        end

        // Flush with a simultaneous push while full.
        set_idle();
        for (int k = 0; k < 2; k++) begin
            drive_op(4'd1, 5'd1, 5'd2, 32'd3 + 32'(k), 32'd4, 1'b0, 32'd0, 5'd5);
            cycle();
        end
        drive_op(4'd2, 5'd1, 5'd2, 32'hF00D, 32'd4, 1'b0, 32'd0, 5'd5);
        bus.flush = 1;
        cycle();
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        set_idle();
        bus.out_ready = 1;
        cycle();
        cycle();
        chk("flush_gone", 32'(bus.out_valid), 32'd0);

        // Reset during operation beats flush and push.
        drive_op(4'd3, 5'd1, 5'd2, 32'd1, 32'd2, 1'b0, 32'd0, 5'd1);
        bus.out_ready = 0;
        cycle();
        rst = 1;
        bus.flush = 1;
        cycle();
        chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        rst = 0;
        set_idle();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 99) == 0);
            bus.flush      = ($urandom_range(0, 29) == 0);
            bus.in_valid   = ($urandom_range(0, 9) < 7);
            bus.out_ready  = ($urandom_range(0, 9) < 6);
            bus.in_control = 4'($urandom_range(0, 15));
            bus.in_rs      = 5'($urandom_range(0, 7));
            bus.in_rt      = 5'($urandom_range(0, 7));
            bus.in_rs_val  = $urandom;
            bus.in_rt_val  = $urandom;
            bus.in_use_imm = ($urandom_range(0, 3) == 0);
            bus.in_imm     = $urandom;
            bus.in_rd      = 5'($urandom_range(0, 31));
            bus.ex_wen     = ($urandom_range(0, 1) == 1);
            bus.ex_rd      = 5'($urandom_range(0, 7));
            bus.ex_data    = $urandom;
            bus.wb_wen     = ($urandom_range(0, 1) == 1);
            bus.wb_rd      = 5'($urandom_range(0, 7));
            bus.wb_data    = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
